// File: rtl/mem_cfg_pkg.sv
// Shared types and constants for the memory-configuration / restart controller.
package mem_cfg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StNmi,
    StFetch,
    StRelease
  } rst_state_e;

  localparam int unsigned CFG_BOOT  = 0;
  localparam int unsigned CFG_F7Q1  = 1;
  localparam int unsigned CFG_RELOK = 2;

  localparam logic BOOT_RST  = 1'b1;
  localparam logic F7Q1_RST  = 1'b0;
  localparam logic RELOK_RST = 1'b0;
  localparam logic NNMI_RST  = 1'b1;
  localparam logic SYNC_RST  = 1'b1;

  localparam int unsigned FETCH_CNT_W = 4;

endpackage

// File: rtl/mem_cfg_restart_if.sv
// Z80 bus signals observed by the restart controller.
interface mem_cfg_restart_if;
  logic [7:0] A;
  logic [2:0] D;
  logic       nIORQ;
  logic       nWR;
  logic       nMREQ;
  logic       nM1;
  logic       nIAH;

  modport master (output A, D, nIORQ, nWR, nMREQ, nM1, nIAH);
  modport slave  (input  A, D, nIORQ, nWR, nMREQ, nM1, nIAH);
endinterface

// File: rtl/mem_cfg_restart_debounce.sv
// Two-flop synchroniser plus consecutive-sample debounce counter for an active-low button.
module mem_cfg_restart_debounce
  import mem_cfg_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_ni,
  output logic level_o,
  output logic fall_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            fall_q, fall_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    fall_d  = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
      // Nth consecutive differing sample: accept the new level.
      level_d = sync2_q;
      cnt_d   = '0;
      fall_d  = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_ni;
      sync2_q <= sync1_q;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/mem_cfg_restart.sv
// Owns BOOT/f7_q1/RELOK from I/O config writes and sequences RESTART: NMI, IAH fetches, release.
module mem_cfg_restart
  import mem_cfg_pkg::*;
#(
  parameter logic [7:0]  CFG_PORT        = 8'hFC,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned NMI_CYCLES      = 8,
  parameter int unsigned IAH_FETCHES     = 4
) (
  input  logic                    CLK,
  input  logic                    nRESET,
  mem_cfg_restart_if.slave        bus,
  input  logic                    nRESTART,
  output logic                    BOOT,
  output logic                    f7_q1,
  output logic                    RELOK,
  output logic                    nNMI,
  output logic                    RST_BUSY
);

  localparam int unsigned NmiW = (NMI_CYCLES > 1) ? $clog2(NMI_CYCLES) : 1;

  // Bit order: {nIORQ, nWR, nMREQ, nM1, nIAH}
  logic [4:0] sync1_q, sync2_q;
  logic       iorq_n, wr_n, mreq_n, m1_n, iah_n;
  logic       iowr_n, iowr_prev_q, cfg_we;
  logic       fetch_lvl, fetch_prev_q, fetch_rise;
  logic       btn_level, btn_fall, press;

  rst_state_e              state_q, state_d;
  logic                    boot_q, boot_d, f7_q, f7_d, relok_q, relok_d, nmi_n_q, nmi_n_d;
  logic [NmiW-1:0]         nmi_cnt_q, nmi_cnt_d;
  logic [FETCH_CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;

  assign {iorq_n, wr_n, mreq_n, m1_n, iah_n} = sync2_q;

  assign iowr_n     = iorq_n | wr_n;
  assign cfg_we     = iowr_prev_q & ~iowr_n & (bus.A == CFG_PORT);
  assign fetch_lvl  = ~m1_n & ~mreq_n & ~iah_n;
  assign fetch_rise = fetch_lvl & ~fetch_prev_q;

  mem_cfg_restart_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i   (CLK),
    .rst_ni  (nRESET),
    .raw_ni  (nRESTART),
    .level_o (btn_level),
    .fall_o  (btn_fall)
  );

  assign press = btn_fall & ~btn_level;

  always_comb begin
    state_d     = state_q;
    boot_d      = boot_q;
    f7_d        = f7_q;
    relok_d     = relok_q;
    nmi_n_d     = nmi_n_q;
    nmi_cnt_d   = nmi_cnt_q;
    fetch_cnt_d = fetch_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (press && relok_q && !boot_q) begin
          f7_d      = 1'b1;
          nmi_n_d   = 1'b0;
          nmi_cnt_d = NmiW'(NMI_CYCLES - 1);
          state_d   = StNmi;
        end
      end
      StNmi: begin
        if (nmi_cnt_q == '0) begin
          nmi_n_d = 1'b1;
          state_d = StFetch;
        end else begin
          nmi_cnt_d = nmi_cnt_q - NmiW'(1);
        end
      end
      StFetch: begin
        if (fetch_rise) begin
          if (fetch_cnt_q != '1) fetch_cnt_d = fetch_cnt_q + FETCH_CNT_W'(1);
          if (32'(fetch_cnt_q) + 32'd1 >= IAH_FETCHES) state_d = StRelease;
        end
      end
      StRelease: begin
        if (m1_n) begin
          f7_d        = 1'b0;
          nmi_cnt_d   = '0;
          fetch_cnt_d = '0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (cfg_we) begin
      boot_d  = bus.D[CFG_BOOT];
      relok_d = bus.D[CFG_RELOK];
      if (state_q == StIdle) begin
        // A press accepted in the same cycle keeps its f7_q1 set.
        if (state_d == StIdle) f7_d = bus.D[CFG_F7Q1];
      end else if (!bus.D[CFG_RELOK]) begin
        f7_d        = 1'b0;
        nmi_n_d     = 1'b1;
        nmi_cnt_d   = '0;
        fetch_cnt_d = '0;
        state_d     = StIdle;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      sync1_q      <= {5{SYNC_RST}};
      sync2_q      <= {5{SYNC_RST}};
      iowr_prev_q  <= 1'b1;
      fetch_prev_q <= 1'b0;
      state_q      <= StIdle;
      boot_q       <= BOOT_RST;
      f7_q         <= F7Q1_RST;
      relok_q      <= RELOK_RST;
      nmi_n_q      <= NNMI_RST;
      nmi_cnt_q    <= '0;
      fetch_cnt_q  <= '0;
    end else begin
      sync1_q      <= {bus.nIORQ, bus.nWR, bus.nMREQ, bus.nM1, bus.nIAH};
      sync2_q      <= sync1_q;
      iowr_prev_q  <= iowr_n;
      fetch_prev_q <= fetch_lvl;
      state_q      <= state_d;
      boot_q       <= boot_d;
      f7_q         <= f7_d;
      relok_q      <= relok_d;
      nmi_n_q      <= nmi_n_d;
      nmi_cnt_q    <= nmi_cnt_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  assign BOOT     = boot_q;
  assign f7_q1    = f7_q;
  assign RELOK    = relok_q;
  assign nNMI     = nmi_n_q;
  assign RST_BUSY = (state_q != StIdle);

endmodule

// File: tb/tb_mem_cfg_restart.sv
// Directed restart-sequence bench plus randomized config writes against a register-level model.
module tb_mem_cfg_restart;

  localparam logic [7:0]  CfgPort = 8'hFC;
  localparam int unsigned Db      = 1024;
  localparam int unsigned NmiC    = 8;
  localparam int unsigned Fetches = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic n_reset, n_restart;
  logic boot, f7, relok, n_nmi, busy;

  mem_cfg_restart_if bus_if ();

  mem_cfg_restart #(
    .CFG_PORT        (CfgPort),
    .DEBOUNCE_CYCLES (Db),
    .NMI_CYCLES      (NmiC),
    .IAH_FETCHES     (Fetches)
  ) dut (
    .CLK      (clk),
    .nRESET   (n_reset),
    .bus      (bus_if),
    .nRESTART (n_restart),
    .BOOT     (boot),
    .f7_q1    (f7),
    .RELOK    (relok),
    .nNMI     (n_nmi),
    .RST_BUSY (busy)
  );

  int   checks = 0;
  int   errors = 0;
  logic saw_nmi, saw_f7;
  logic exp_boot, exp_f7, exp_relok;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_mon(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (n_nmi === 1'b0) saw_nmi = 1'b1;
      if (f7 === 1'b1) saw_f7 = 1'b1;
    end
  endtask

  task automatic wait_nmi(input logic lvl, input int budget, output int cyc);
    cyc = 0;
    while (n_nmi !== lvl && cyc < budget) begin
      tick();
      cyc++;
    end
    chk("wait_nmi", {15'd0, n_nmi}, {15'd0, lvl});
  endtask

  task automatic cfg_write(input logic [7:0] addr, input logic [2:0] data);
    bus_if.A     = addr;
    bus_if.D     = data;
    bus_if.nIORQ = 1'b0;
    tick();
    bus_if.nWR = 1'b0;
    tick(3);
  endtask

  task automatic cfg_release();
    bus_if.nWR   = 1'b1;
    bus_if.nIORQ = 1'b1;
    tick(4);
  endtask

  task automatic fetch(input logic iah);
    bus_if.nM1   = 1'b0;
    bus_if.nMREQ = 1'b0;
    bus_if.nIAH  = iah;
    tick(4);
    bus_if.nM1   = 1'b1;
    bus_if.nMREQ = 1'b1;
    bus_if.nIAH  = 1'b1;
    tick(4);
  endtask

  initial begin
    int cyc, low;
    logic [7:0] addr;
    logic [2:0] data;

    n_reset = 1'b0; n_restart = 1'b1;
    bus_if.A = 8'h00; bus_if.D = 3'b000;
    bus_if.nIORQ = 1'b1; bus_if.nWR = 1'b1; bus_if.nMREQ = 1'b1;
    bus_if.nM1 = 1'b1; bus_if.nIAH = 1'b1;
    tick(2);
    chk("rst_boot", 16'(boot), 16'd1);
    chk("rst_f7", 16'(f7), 16'd0);
    chk("rst_relok", 16'(relok), 16'd0);
    chk("rst_nnmi", 16'(n_nmi), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    n_reset = 1'b1;
    tick(2);

    // Config write latency: outputs move on the 3rd edge after nWR falls.
    bus_if.A = CfgPort; bus_if.D = 3'b100; bus_if.nIORQ = 1'b0;
    tick();
    bus_if.nWR = 1'b0;
    tick(2);
    chk("wr_edge2_boot", 16'(boot), 16'd1);
    chk("wr_edge2_relok", 16'(relok), 16'd0);
    tick();
    chk("wr_edge3_boot", 16'(boot), 16'd0);
    chk("wr_edge3_relok", 16'(relok), 16'd1);
    chk("wr_edge3_f7", 16'(f7), 16'd0);
    cfg_release();

    cfg_write(8'hFD, 3'b011);
    tick(2);
    chk("wr_fd_boot", 16'(boot), 16'd0);
    chk("wr_fd_relok", 16'(relok), 16'd1);
    chk("wr_fd_f7", 16'(f7), 16'd0);
    cfg_release();

    // Bounces shorter than the debounce window must not register.
    saw_nmi = 1'b0; saw_f7 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_restart = 1'b0;
      tick_mon(int'($urandom_range(1, Db / 2)));
      n_restart = 1'b1;
      tick_mon(int'($urandom_range(5, 40)));
    end
    chk("bounce_no_nmi", 16'(saw_nmi), 16'd0);
    chk("bounce_no_f7", 16'(saw_f7), 16'd0);

    n_restart = 1'b0;
    wait_nmi(1'b0, int'(Db) + 20, cyc);
    chk("press_latency", 16'(cyc >= int'(Db) && cyc <= int'(Db) + 6), 16'd1);
    chk("press_f7", 16'(f7), 16'd1);
    chk("press_busy", 16'(busy), 16'd1);
    low = 0;
    while (n_nmi === 1'b0 && low < 50) begin
      tick();
      low++;
    end
    chk("nmi_width", 16'(low), 16'(NmiC));
    n_restart = 1'b1;

    fetch(1'b0);
    chk("fetch1_f7", 16'(f7), 16'd1);
    fetch(1'b1);
    fetch(1'b0);
    fetch(1'b1);
    fetch(1'b0);
    chk("fetch3_f7", 16'(f7), 16'd1);
    chk("fetch3_busy", 16'(busy), 16'd1);
    bus_if.nM1 = 1'b0; bus_if.nMREQ = 1'b0; bus_if.nIAH = 1'b0;
    tick(4);
    chk("fetch4_m1low_f7", 16'(f7), 16'd1);
    chk("fetch4_m1low_busy", 16'(busy), 16'd1);
    bus_if.nM1 = 1'b1; bus_if.nMREQ = 1'b1; bus_if.nIAH = 1'b1;
    cyc = 0;
    while (f7 !== 1'b0 && cyc < 8) begin
      tick();
      cyc++;
    end
    chk("release_f7", 16'(f7), 16'd0);
    chk("release_busy", 16'(busy), 16'd0);
    tick(int'(Db) + 10);

    // Second press, aborted by a config write clearing RELOK during FETCH.
    n_restart = 1'b0;
    wait_nmi(1'b0, int'(Db) + 20, cyc);
    wait_nmi(1'b1, 50, cyc);
    n_restart = 1'b1;
    fetch(1'b0);
    chk("abort_pre_busy", 16'(busy), 16'd1);
    cfg_write(CfgPort, 3'b000);
    chk("abort_f7", 16'(f7), 16'd0);
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_nnmi", 16'(n_nmi), 16'd1);
    chk("abort_relok", 16'(relok), 16'd0);
    cfg_release();
    for (int i = 0; i < int'(Fetches); i++) fetch(1'b0);
    chk("abort_stays_idle", 16'({busy, f7}), 16'd0);
    tick(int'(Db) + 10);

    // Press with RELOK=0 is ignored.
    saw_nmi = 1'b0; saw_f7 = 1'b0;
    n_restart = 1'b0;
    tick_mon(int'(Db) + 30);
    chk("relok0_no_nmi", 16'(saw_nmi), 16'd0);
    chk("relok0_no_f7", 16'(saw_f7), 16'd0);
    chk("relok0_busy", 16'(busy), 16'd0);
    n_restart = 1'b1;
    tick(int'(Db) + 10);

    // Reset in the middle of NMI.
    cfg_write(CfgPort, 3'b100);
    cfg_release();
    n_restart = 1'b0;
    wait_nmi(1'b0, int'(Db) + 20, cyc);
    tick(2);
    chk("midnmi_pre_nnmi", 16'(n_nmi), 16'd0);
    n_reset = 1'b0;
    tick();
    chk("midnmi_nnmi", 16'(n_nmi), 16'd1);
    chk("midnmi_f7", 16'(f7), 16'd0);
    chk("midnmi_boot", 16'(boot), 16'd1);
    chk("midnmi_busy", 16'(busy), 16'd0);
    n_reset = 1'b1;
    n_restart = 1'b1;
    tick(int'(Db) + 10);

    // Random config writes in IDLE against a register-level model.
    exp_boot = 1'b1; exp_f7 = 1'b0; exp_relok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr = ($urandom_range(0, 1) == 0) ? CfgPort : 8'($urandom_range(0, 255));
      data = 3'($urandom_range(0, 7));
      cfg_write(addr, data);
      if (addr == CfgPort) begin
        exp_boot  = data[0];
        exp_f7    = data[1];
        exp_relok = data[2];
      end
      chk("rand_cfg", 16'({boot, f7, relok}), 16'({exp_boot, exp_f7, exp_relok}));
      cfg_release();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_cfg_restart.md
Name: mem_cfg_restart

Overview:
- Memory-configuration and RESTART controller feeding the memory address decoder.
- Owns and drives the three map-control signals BOOT, f7_q1 and RELOK.
- Captures them from Z80 I/O writes to a config port.
- Runs the RESTART sequence: debounced button, then NMI, then a bounded number of opcode fetches through the IAH window, then release of f7_q1.

Parameters:
- CFG_PORT, 8'hFC, I/O port address (A[7:0]) of the config register.
- DEBOUNCE_CYCLES, 1024, consecutive CLK cycles nRESTART must hold a new level before it is accepted.
- NMI_CYCLES, 8, CLK cycles nNMI is held low.
- IAH_FETCHES, 4, M1 fetches with nIAH low before f7_q1 is released (range 1..15).

Ports:
- CLK  in  1  system clock, faster than Z80 bus; all Z80 strobes asynchronous to it.
- nRESET  in  1  synchronous active-low reset.
- A  in  8  Z80 address low byte.
- D  in  3  Z80 data bits 2:0.
- nIORQ  in  1  Z80 I/O request.
- nWR  in  1  Z80 write strobe.
- nMREQ  in  1  Z80 memory request.
- nM1  in  1  Z80 M1.
- nIAH  in  1  IAH window select from the address decoder.
- nRESTART  in  1  RESTART pushbutton, active low, bouncy.
- BOOT  out  1  boot ROM mapped.
- f7_q1  out  1  restart/IAH mapping flag.
- RELOK  out  1  relocation enable.
- nNMI  out  1  Z80 NMI, active low.
- RST_BUSY  out  1  high while the restart FSM is not IDLE.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous, active-low nRESET, sampled on CLK rising edge.
- Reset values:
  - BOOT=1, f7_q1=0, RELOK=0, nNMI=1, RST_BUSY=0.
  - FSM=IDLE; fetch and NMI counters cleared.
  - Debounced button level = 1 (released).
  - Synchroniser flops preset to 1.
- Synchronisers: nIORQ, nWR, nMREQ, nM1, nIAH, nRESTART each go through 2 flops.
- Config write:
  - Trigger: one-cycle pulse on the synchronised falling edge of (nIORQ|nWR) while A==CFG_PORT.
  - A and D are sampled from the pins in the pulse cycle; they are stable during the strobe.
  - Update: BOOT<=D[0], f7_q1<=D[1], RELOK<=D[2].
  - Latency: outputs change on the 3rd CLK edge after the strobe goes low.
  - One write per strobe; the strobe held low gives no repeat.
  - D[1] is ignored unless FSM=IDLE. BOOT and RELOK are always written.
- Debounce:
  - Counter resets whenever raw synced nRESTART equals the debounced level.
  - Debounced level flips after DEBOUNCE_CYCLES consecutive differing samples.
  - A press event is the debounced 1->0 transition.
- Restart FSM:
  - IDLE: on press with RELOK=1 and BOOT=0, set f7_q1=1, load the NMI counter, go NMI. Press otherwise ignored.
  - NMI: nNMI=0 for exactly NMI_CYCLES cycles, then nNMI=1 and go FETCH.
  - FETCH: count rising edges of synced (~nM1 & ~nMREQ & ~nIAH). When the count reaches IAH_FETCHES, go RELEASE.
  - RELEASE: wait for synced nM1=1, then clear f7_q1, clear counters, go IDLE.
  - RST_BUSY=1 in NMI, FETCH and RELEASE.
- Aborts and simultaneous events:
  - A config write clearing RELOK in any non-IDLE state aborts the sequence: f7_q1<=0, nNMI<=1, FSM<=IDLE in that same cycle.
  - Press while non-IDLE is ignored; the sequence never re-triggers.
  - The fetch counter saturates; no wrap.
  - nRESET mid-sequence returns everything to reset values next edge.

Decomposition:
- Shared package mem_cfg_pkg holds:
  - FSM state typedef (IDLE, NMI, FETCH, RELEASE).
  - CFG bit index constants (CFG_BOOT=0, CFG_F7Q1=1, CFG_RELOK=2).
  - Reset-value constants.
- Sub-module debounce: synchroniser plus counter; parameter DEBOUNCE_CYCLES; outputs level and fall pulse. Instantiated once for nRESTART.

Test Plan:
- Reset sequence: hold nRESET low 2 cycles -> BOOT=1, f7_q1=0, RELOK=0, nNMI=1, RST_BUSY=0.
- Config write: I/O write A=8'hFC, D=3'b100 -> BOOT=0, RELOK=1, f7_q1=0 on the 3rd CLK after nWR falls. Same data at A=8'hFD -> no change.
- Debounce: nRESTART bounces with pulses shorter than DEBOUNCE_CYCLES -> no press. Held low for DEBOUNCE_CYCLES (RELOK=1, BOOT=0) -> f7_q1=1 and nNMI low for exactly 8 cycles.
- Fetch release: 4 M1 fetches with nIAH=0 plus 2 fetches with nIAH=1 interleaved -> f7_q1 clears only after the 4th nIAH fetch and nM1 returns high; RST_BUSY then falls.
- Aborts: during FETCH, write D=3'b000 -> f7_q1=0, FSM IDLE the same cycle. Separately, press with RELOK=0 -> no NMI, f7_q1 stays 0.
- Reset mid-NMI: assert nRESET while nNMI=0 -> nNMI=1, f7_q1=0, BOOT=1 on the next edge.
